// File: rtl/wb_arbiter_pkg.sv
// Shared widths and constants for the write-back arbiter slice.
package wb_arbiter_pkg;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DEPTH  = 2;

    localparam logic                 WRITE_ENABLE = 1'b1;
    localparam logic [WB_ADDR_W-1:0] REG_ZERO     = '0;
    localparam logic [WB_DATA_W-1:0] ZERO_WORD    = '0;

    typedef logic [WB_DATA_W-1:0] reg_t;
    typedef logic [WB_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/wb_queue.sv
// Long-latency result queue: in-order storage with per-entry live bits,
// kill-by-address and youngest-match forwarding.
module wb_queue
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic [ADDR_W-1:0] enq_addr,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              pop,
    input  logic              kill,
    input  logic [ADDR_W-1:0] kill_addr,
    output logic              head_live,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    count,
    input  logic [ADDR_W-1:0] fwd_raddr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);
    logic [DEPTH-1:0]             live;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PTR_W-1:0]             head, tail;
    logic                         enq_live;

    // The pipe write is program-order younger than anything arriving alongside it.
    assign enq_live  = !(kill && kill_addr == enq_addr);
    assign head_live = live[head];
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            live  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill && addr_q[i] == kill_addr) live[i] <= 1'b0;
            // Slots outside the occupied window stay non-live so forwarding needs no range test.
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + 1'b1;
            end
            if (enq) begin
                live[tail] <= enq_live;
                tail       <= tail + 1'b1;
            end
            count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= enq_addr;
            data_q[tail] <= enq_data;
        end
    end

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (live[idx] && addr_q[idx] == fwd_raddr && fwd_raddr != '0) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: MEM/WB results take priority, long-latency results
// drain from the queue, all through one registered regfile write stage.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [ADDR_W-1:0]        pipe_waddr,
    input  logic [DATA_W-1:0]        pipe_wdata,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [ADDR_W-1:0]        lu_waddr,
    input  logic [DATA_W-1:0]        lu_wdata,
    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    input  logic [ADDR_W-1:0]        fwd_raddr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   q_count
);
    logic              pipe_win, enq, pop;
    logic              head_live, empty, full;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign pipe_win = pipe_we && pipe_waddr != ADDR_W'(REG_ZERO);
    assign lu_ready = !rst && !full;
    // Results to r0 are accepted but dropped.
    assign enq      = lu_valid && lu_ready && lu_waddr != ADDR_W'(REG_ZERO);
    // Dead heads are always discarded; a live head only leaves when it issues.
    assign pop      = !empty && (!head_live || !pipe_win);

    wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq),
        .enq_addr  (lu_waddr),
        .enq_data  (lu_wdata),
        .pop       (pop),
        .kill      (pipe_win),
        .kill_addr (pipe_waddr),
        .head_live (head_live),
        .head_addr (head_addr),
        .head_data (head_data),
        .empty     (empty),
        .full      (full),
        .count     (q_count),
        .fwd_raddr (fwd_raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= ADDR_W'(REG_ZERO);
            wdata <= DATA_W'(ZERO_WORD);
        end else if (pipe_win) begin
            we    <= WRITE_ENABLE;
            waddr <= pipe_waddr;
            wdata <= pipe_wdata;
        end else if (head_live) begin
            we    <= WRITE_ENABLE;
            waddr <= head_addr;
            wdata <= head_data;
        end else begin
            we    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-level reference model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we, lu_valid, lu_ready, we, fwd_hit;
    logic [4:0]  pipe_waddr, lu_waddr, waddr, fwd_raddr;
    logic [31:0] pipe_wdata, lu_wdata, wdata, fwd_data;
    logic [1:0]  q_count;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .q_count(q_count)
    );

    typedef struct {logic [4:0] a; logic [31:0] d; bit live;} ent_t;
    ent_t        mq[$];
    int          n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of traffic: check start-of-cycle outputs, advance the model, check the write stage.
    task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] fa, output bit acc);
        bit          pw, do_pop, hit, ewe;
        logic [31:0] fd, ed;
        logic [4:0]  ea;
        ent_t        e;
        pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld; fwd_raddr = fa;
        #1;
        hit = 0; fd = 0;
        foreach (mq[i]) if (mq[i].live && mq[i].a == fa && fa != 0) begin hit = 1; fd = mq[i].d; end
        check("lu_ready", lu_ready, mq.size() < DEPTH);
        check("q_count", q_count, mq.size());
        check("fwd_hit", fwd_hit, hit);
        check("fwd_data", fwd_data, fd);
        acc = lv && mq.size() < DEPTH;
        pw  = pwe && pa != 0;
        ewe = 0; ea = 0; ed = 0; do_pop = 0;
        if (pw) begin ewe = 1; ea = pa; ed = pd; end
        else if (mq.size() > 0 && mq[0].live) begin ewe = 1; ea = mq[0].a; ed = mq[0].d; end
        if (mq.size() > 0 && (!mq[0].live || !pw)) do_pop = 1;
        if (do_pop) void'(mq.pop_front());
        if (pw) foreach (mq[i]) if (mq[i].a == pa) mq[i].live = 0;
        if (acc && la != 0) begin
            e.a = la; e.d = ld; e.live = !(pw && la == pa);
            mq.push_back(e);
        end
        @(posedge clk); #1;
        check("we", we, ewe);
        if (ewe) begin
            check("waddr", waddr, ea);
            check("wdata", wdata, ed);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lu_valid = 1'b1; pipe_we = $urandom_range(0, 1);
        pipe_waddr = 5'($urandom); lu_waddr = 5'($urandom); fwd_raddr = 5'($urandom);
        #1;
        check("rst_lu_ready", lu_ready, 0);
        @(posedge clk); #1;
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_lu_ready2", lu_ready, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        check("rst_fwd_data", fwd_data, 0);
        check("rst_q_count", q_count, 0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit         acc;
        int         k;
        logic [4:0] la3[3];
        logic [31:0] ld3[3];
        rst = 1'b1; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        lu_valid = 0; lu_waddr = 0; lu_wdata = 0; fwd_raddr = 0;
        @(negedge clk);
        do_reset();
        do_reset();

        // Idle after reset, then a single lu result to r3.
        step(0, 0, 0, 0, 0, 0, 3, acc);
        step(0, 0, 0, 1, 3, 32'h11, 3, acc);
        check("lu_acc", acc, 1);
        step(0, 0, 0, 0, 0, 0, 3, acc);
        check("lu_we", we, 1);
        check("lu_waddr", waddr, 3);
        check("lu_wdata", wdata, 32'h11);
        step(0, 0, 0, 0, 0, 0, 3, acc);

        // Pipe priority with the queue filling up.
        la3[0] = 4; la3[1] = 5; la3[2] = 6;
        ld3[0] = 32'hA; ld3[1] = 32'hB; ld3[2] = 32'hC;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            step(1, 5'(1 + c % 2), 32'(100 + c), k < 3, la3[k % 3], ld3[k % 3], 4, acc);
            if (acc) k++;
        end
        check("full_k", k, 2);
        check("full_cnt", q_count, 2);
        for (int t = 0; t < 20 && k < 3; t++) begin
            step(0, 0, 0, 1, la3[k], ld3[k], 5, acc);
            if (acc) k++;
        end
        check("drain_k", k, 3);
        repeat (4) step(0, 0, 0, 0, 0, 0, 6, acc);

        // WAW kill of a queued entry, then simultaneous kill and enqueue.
        step(1, 1, 32'h77, 1, 7, 32'h1, 7, acc);
        step(1, 7, 32'h2, 0, 0, 0, 7, acc);
        step(0, 0, 0, 0, 0, 0, 7, acc);
        check("kill_hit", fwd_hit, 0);
        step(1, 9, 32'h5, 1, 9, 32'h6, 9, acc);
        repeat (3) step(0, 0, 0, 0, 0, 0, 9, acc);

        // Register zero from both sources, then wrap with 10 back-to-back lu writes.
        step(1, 0, 32'h1, 1, 0, 32'h2, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, acc);
        check("r0_we", we, 0);
        k = 0;
        for (int t = 0; t < 40 && k < 10; t++) begin
            step(0, 0, 0, 1, 5'(10 + k), 32'(1000 + k), 5'(10 + k), acc);
            if (acc) k++;
        end
        check("wrap_k", k, 10);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, acc);

        // Random traffic with occasional mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                      5'($urandom_range(0, 7)), acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
